cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Miss-service controller between the two caches and the multi-cycle main memory. It accepts block-fill requests from the I-cache and D-cache miss detectors and arbitrates between them. It issues one 8-word block read to memory as pipelined word addresses. Each returned word is written into the requesting cache's data array, and the tag array is written on the last word. It drives the per-side busy signals that form the pipeline's `i_cache_miss` / `d_cache_miss` stall terms.

## Interface
Parameters:
- `BLOCK_WORDS`, 8, 16-bit words per cache block (power of 2; block = 2*BLOCK_WORDS bytes)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `i_miss`  in  1  I-cache miss request, level, held until `i_write_tag` seen
- `i_miss_addr`  in  16  I-side miss byte address
- `d_miss`  in  1  D-cache miss request, level, held until `d_write_tag` seen
- `d_miss_addr`  in  16  D-side miss byte address
- `i_busy`  out  1  fill in progress for I-side
- `d_busy`  out  1  fill in progress for D-side
- `mem_enable`  out  1  memory read request this cycle
- `mem_addr`  out  16  word address to memory; 0 when `mem_enable`=0
- `mem_data_valid`  in  1  memory returns a word this cycle (in request order)
- `mem_data`  in  16  returned word
- `fill_addr`  out  16  byte address of the word being written (index + tag source)
- `fill_data`  out  16  word to write (= `mem_data`)
- `i_write_data` / `d_write_data`  out  1  data-array write strobe, selected side
- `i_write_tag` / `d_write_tag`  out  1  tag-array write strobe, selected side

## Operation
- States: IDLE, FILL. Registers: `side` (I/D), `base` (16 b), `issue_cnt` and `recv_cnt` (log2(BLOCK_WORDS)+1 b).
- In IDLE, when `d_miss` or `i_miss` is set, move to FILL at the clock edge.
  - If both are set, D-side wins.
  - Latch `side` and `base` = miss_addr with the low log2(2*BLOCK_WORDS) bits cleared (0xFFF0 mask for 8).
  - Clear both counters.
- FILL, issue phase: while `issue_cnt` < BLOCK_WORDS:
  - `mem_enable`=1 and `mem_addr` = `base` + 2*`issue_cnt`.
  - `issue_cnt` increments every cycle; no back-pressure from memory.
- FILL, receive: on every `mem_data_valid`:
  - `fill_addr` = `base` + 2*`recv_cnt` and `fill_data` = `mem_data`.
  - Selected side's `*_write_data` = 1; `recv_cnt` increments.
  - Receive can overlap issue.
- Completion: the cycle with `mem_data_valid` and `recv_cnt` = BLOCK_WORDS-1 also asserts the selected `*_write_tag`. The next state is IDLE.
- `i_busy` = (state==FILL & side==I); `d_busy` = (state==FILL & side==D). Both are decoded from state; no glitch from requests.
- `mem_data_valid` in IDLE is ignored (no strobes).
- Address arithmetic is 16-bit modulo, but base alignment guarantees no carry past the block.
- A request arriving during FILL waits; it is served from IDLE after completion. There is exactly one IDLE cycle between back-to-back fills.
- Write-strobe outputs are combinational from state, `recv_cnt` and `mem_data_valid`. `mem_enable`/`mem_addr` depend only on registers.

## Timing
- Reset (async): state IDLE, counters 0, `side`=D, `base`=0.
  - All outputs are 0 while `rst` is high and afterwards until a request is accepted.
  - Reset mid-fill aborts immediately; the memory is reset by the same `rst`, so no stale returns.
- Request at edge E0 → `*_busy` and `mem_enable` high from cycle 1 (first cycle after E0).
- Addresses are issued in cycles 1..BLOCK_WORDS.
- With a fixed memory latency L (data valid L cycles after its address cycle): words arrive in cycles 1+L..BLOCK_WORDS+L. Busy lasts BLOCK_WORDS+L cycles (12 for L=4); the tag write occurs in cycle BLOCK_WORDS+L.
- Gaps in `mem_data_valid` stretch the fill; completion is counted by valid words only.

## Test plan
- **I miss only**, `i_miss_addr`=0x1234, L=4:
  - `mem_addr` 0x1230,0x1232..0x123E in cycles 1-8.
  - 8 `i_write_data` pulses in cycles 5-12 with `fill_addr` 0x1230..0x123E.
  - `i_write_tag` in cycle 12; `i_busy` high cycles 1-12.
  - All D strobes and `d_busy` stay 0.
- **Simultaneous** `i_miss`@0x0040 and `d_miss`@0x8006:
  - D fill first (base 0x8000, `d_busy` 12 cycles).
  - One IDLE cycle, then I fill at base 0x0040.
- **D miss raised in cycle 3 of an active I fill**: no D activity until the I tag write. D fill starts after the following IDLE cycle, base = D address & 0xFFF0.
- **Memory with bubbles**: valid returned on alternate cycles → 8 writes at consecutive `fill_addr`. Tag write is only on the 8th valid; busy is extended accordingly.
- **Reset asserted in cycle 6 of a fill**:
  - All outputs 0 immediately, no further strobes.
  - After release with no request, the block stays idle with `mem_enable`=0.
- **Top-of-memory**: `d_miss_addr`=0xFFFE → `mem_addr` 0xFFF0..0xFFFE, last `fill_addr` 0xFFFE, no wrap to 0x0000.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Block-fill controller: arbitrates I/D cache misses and streams one aligned block
// from memory into the winning cache, writing the tag with the final word.
module cache_fill_ctrl #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    output logic        i_busy,
    output logic        d_busy,
    output logic        mem_enable,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic [15:0] fill_addr,
    output logic [15:0] fill_data,
    output logic        i_write_data,
    output logic        d_write_data,
    output logic        i_write_tag,
    output logic        d_write_tag
);

    localparam int CW = $clog2(BLOCK_WORDS) + 1;
    localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);
    localparam logic [15:0] ALIGN_MASK = ~16'(2 * BLOCK_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state;
    state_t        state_next;
    logic          side_d;
    logic [15:0]   base;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] recv_cnt;
    logic          last_word;

    assign last_word = (state == FILL) && mem_data_valid && (recv_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (d_miss || i_miss) state_next = FILL;
            FILL:    if (last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // D-side wins a simultaneous request; counters restart with every accepted miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_d    <= 1'b1;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (state == IDLE) begin
            if (d_miss || i_miss) begin
                side_d    <= d_miss;
                base      <= (d_miss ? d_miss_addr : i_miss_addr) & ALIGN_MASK;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
        end else begin
            if (issue_cnt < FULL) issue_cnt <= issue_cnt + 1'b1;
            if (mem_data_valid) recv_cnt <= recv_cnt + 1'b1;
        end
    end

    always_comb begin
        i_busy       = 1'b0;
        d_busy       = 1'b0;
        mem_enable   = 1'b0;
        mem_addr     = '0;
        fill_addr    = '0;
        fill_data    = '0;
        i_write_data = 1'b0;
        d_write_data = 1'b0;
        i_write_tag  = 1'b0;
        d_write_tag  = 1'b0;
        if (state == FILL) begin
            i_busy = ~side_d;
            d_busy = side_d;
            if (issue_cnt < FULL) begin
                mem_enable = 1'b1;
                mem_addr   = base + 16'({issue_cnt, 1'b0});
            end
            // Fill address and data are held at 0 outside a write so idle outputs stay quiet.
            if (mem_data_valid) begin
                fill_addr    = base + 16'({recv_cnt, 1'b0});
                fill_data    = mem_data;
                i_write_data = ~side_d;
                d_write_data = side_d;
                i_write_tag  = ~side_d && last_word;
                d_write_tag  = side_d && last_word;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl: a latency/bubble memory model, an expected-block
// scoreboard for issued addresses and cache writes, and directed corner cases.
module tb_cache_fill_ctrl;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic        i_busy, d_busy;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic [15:0] fill_addr, fill_data;
    logic        i_write_data, d_write_data, i_write_tag, d_write_tag;

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_iss[$];
    logic [35:0] exp_wr[$];

    logic [15:0] pend_a[$];
    int          pend_t[$];
    int          cyc     = 0;
    int          lat_cfg = 4;
    bit          bub_cfg = 1'b0;
    bit          len_chk = 1'b0;
    logic [15:0] salt    = '0;

    cache_fill_ctrl #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .i_busy(i_busy), .d_busy(d_busy),
        .mem_enable(mem_enable), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .fill_addr(fill_addr), .fill_data(fill_data),
        .i_write_data(i_write_data), .d_write_data(d_write_data),
        .i_write_tag(i_write_tag), .d_write_tag(d_write_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ salt;
    endfunction

    // A fill of side sd for a miss at a: the aligned block, word by word, tag on the last.
    task automatic push_fill(input bit sd, input logic [15:0] a);
        logic [15:0] b;
        logic [15:0] w;
        b = a & ~16'(2 * BW - 1);
        for (int i = 0; i < BW; i++) begin
            w = b + 16'(2 * i);
            exp_iss.push_back({~sd, sd, w});
            exp_wr.push_back({~sd, sd, (~sd) && (i == BW - 1), sd && (i == BW - 1), w, mem_word(w)});
        end
    endtask

    // Memory: an address seen in cycle c may return from cycle c+lat_cfg, in order.
    initial begin
        mem_data_valid = 1'b0;
        mem_data       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_a.delete();
                pend_t.delete();
            end else if (mem_enable) begin
                pend_a.push_back(mem_addr);
                pend_t.push_back(cyc + lat_cfg);
            end
            @(posedge clk);
            #1;
            cyc++;
            mem_data_valid = 1'b0;
            mem_data       = 16'($urandom);
            if (!rst && pend_a.size() > 0 && pend_t[0] <= cyc &&
                (!bub_cfg || $urandom_range(0, 1) == 1)) begin
                mem_data_valid = 1'b1;
                mem_data       = mem_word(pend_a.pop_front());
                void'(pend_t.pop_front());
            end
        end
    end

    bit prev_busy = 1'b0;
    bit prev_tag  = 1'b0;
    int run_len   = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            prev_tag  = 1'b0;
            run_len   = 0;
        end else begin
            if (prev_tag) chk("idle_gap", 64'({i_busy, d_busy}), 64'(0));
            if (mem_enable) begin
                if (exp_iss.size() == 0) fail_now("unexp_issue", 64'(mem_addr));
                else chk("issue", 64'({i_busy, d_busy, mem_addr}), 64'(exp_iss.pop_front()));
            end
            if (i_write_data || d_write_data || i_write_tag || d_write_tag) begin
                if (exp_wr.size() == 0) fail_now("unexp_write", 64'(fill_addr));
                else chk("write", 64'({i_write_data, d_write_data, i_write_tag, d_write_tag,
                                        fill_addr, fill_data}), 64'(exp_wr.pop_front()));
            end
            if (i_busy || d_busy) run_len = prev_busy ? run_len + 1 : 1;
            else if (prev_busy && len_chk) chk("busy_len", 64'(run_len), 64'(BW + lat_cfg));
            prev_busy = i_busy || d_busy;
            prev_tag  = i_write_tag || d_write_tag;
        end
    end

    // kind: 0 I only, 1 D only, 2 both together, 3 D raised in cycle 3 of I, 4 I raised in cycle 3 of D
    task automatic run_case(input int kind, input logic [15:0] ia, input logic [15:0] da,
                            input int lat, input bit bub);
        bit first_d, i_done, d_done, drop_i, drop_d;
        lat_cfg = lat;
        bub_cfg = bub;
        len_chk = !bub;
        salt    = 16'($urandom);
        first_d = (kind == 1) || (kind == 2) || (kind == 4);
        if (kind == 0) push_fill(1'b0, ia);
        else if (kind == 1) push_fill(1'b1, da);
        else if (first_d) begin push_fill(1'b1, da); push_fill(1'b0, ia); end
        else begin push_fill(1'b0, ia); push_fill(1'b1, da); end
        i_done = (kind == 1);
        d_done = (kind == 0);
        drop_i = 1'b0;
        drop_d = 1'b0;
        @(posedge clk);
        #1;
        i_miss_addr = ia;
        d_miss_addr = da;
        i_miss = (kind == 0) || (kind == 2) || (kind == 3);
        d_miss = first_d;
        for (int k = 1; k <= 400 && !(i_done && d_done); k++) begin
            @(posedge clk);
            #1;
            if (drop_i) begin i_miss = 1'b0; drop_i = 1'b0; end
            if (drop_d) begin d_miss = 1'b0; drop_d = 1'b0; end
            if (k == 3 && kind == 3) d_miss = 1'b1;
            if (k == 3 && kind == 4) i_miss = 1'b1;
            @(negedge clk);
            if (k == 1) chk("start_busy", 64'({i_busy, d_busy, mem_enable}),
                            64'(first_d ? 3'b011 : 3'b101));
            if (i_write_tag) begin i_done = 1'b1; drop_i = 1'b1; end
            if (d_write_tag) begin d_done = 1'b1; drop_d = 1'b1; end
        end
        chk("fill_done", 64'({i_done, d_done}), 64'(2'b11));
        @(posedge clk);
        #1;
        i_miss = 1'b0;
        d_miss = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("iss_q_left", 64'(exp_iss.size()), 64'(0));
        chk("wr_q_left", 64'(exp_wr.size()), 64'(0));
        exp_iss.delete();
        exp_wr.delete();
    endtask

    task automatic reset_mid_fill(input logic [15:0] ia);
        lat_cfg = 4;
        bub_cfg = 1'b0;
        len_chk = 1'b1;
        salt    = 16'($urandom);
        push_fill(1'b0, ia);
        @(posedge clk);
        #1;
        i_miss_addr = ia;
        i_miss      = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 64'({i_busy, d_busy, mem_enable, mem_addr, fill_addr, fill_data,
                                    i_write_data, d_write_data, i_write_tag, d_write_tag}), 64'(0));
        exp_iss.delete();
        exp_wr.delete();
        i_miss = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_idle", 64'({mem_enable, i_busy, d_busy}), 64'(0));
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_miss      = 1'b0;
        d_miss      = 1'b0;
        i_miss_addr = '0;
        d_miss_addr = '0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 64'({i_busy, d_busy, mem_enable, mem_addr, fill_addr, fill_data,
                                      i_write_data, d_write_data, i_write_tag, d_write_tag}), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_case(0, 16'h1234, 16'h0000, 4, 1'b0);
        run_case(2, 16'h0040, 16'h8006, 4, 1'b0);
        run_case(3, 16'h2222, 16'h5A5B, 4, 1'b0);
        run_case(0, 16'h3456, 16'h0000, 3, 1'b1);
        run_case(1, 16'h0000, 16'h7777, 2, 1'b1);
        run_case(1, 16'h0000, 16'hFFFE, 4, 1'b0);
        reset_mid_fill(16'h4444);
        repeat (25) begin
            run_case(int'($urandom_range(0, 4)), 16'($urandom), 16'($urandom),
                     int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
